// File: rtl/pooling_window_feeder_if.sv
// Streaming bus for pooling_window_feeder: row-major feature-map input and
// pooled-value output, both valid/ready handshakes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface pooling_window_feeder_if;
    logic                   in_valid;
    logic [`DATA_WIDTH-1:0] in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [`DATA_WIDTH-1:0] out_data;
    logic                   out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pooling_window_feeder.sv
// Buffers a row pair and sequences an external max cell over each 2x2 window.
// Optional POOL_OUT_LAST_EN adds out_last, marking the final window of a frame.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_window_feeder #(
    parameter int unsigned FM_WIDTH  = 8,
    parameter int unsigned FM_HEIGHT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pooling_window_feeder_if.slave bus,
    output logic [`DATA_WIDTH-1:0] cell_data,
    output logic                   cell_clear,
    input  logic [`DATA_WIDTH-1:0] cell_result
`ifdef POOL_OUT_LAST_EN
    ,
    output logic                   out_last
`endif
);
    localparam int unsigned DW    = `DATA_WIDTH;
    localparam int unsigned NBUF  = 2 * FM_WIDTH;
    localparam int unsigned NWIN  = FM_WIDTH / 2;
    localparam int unsigned WR_W  = $clog2(NBUF);
    localparam int unsigned WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(NBUF - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NWIN - 1);

    if (FM_WIDTH < 2 || (FM_WIDTH % 2) != 0 || FM_HEIGHT < 2 || (FM_HEIGHT % 2) != 0) begin : g_param_check
        $error("pooling_window_feeder: FM_WIDTH and FM_HEIGHT must be even and >= 2");
    end

    typedef enum logic {LOAD, POOL} state_t;

    state_t           state_q, state_d;
    logic [WR_W-1:0]  wr_q, wr_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [2:0]       ph_q, ph_d;
    logic             ov_q, ov_d;
    logic [DW-1:0]    od_q, od_d;
    logic [WR_W-1:0]  base;
    logic [DW-1:0]    row_buf [NBUF];

`ifdef POOL_OUT_LAST_EN
    localparam int unsigned NPAIR  = FM_HEIGHT / 2;
    localparam int unsigned PAIR_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NPAIR - 1);
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic              ol_q, ol_d;
    assign out_last = ol_q;
`endif

    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;

    // Buffer is deliberately unreset; a reset simply restarts the write index.
    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            row_buf[wr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            wr_q    <= '0;
            win_q   <= '0;
            ph_q    <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
`ifdef POOL_OUT_LAST_EN
            pair_q  <= '0;
            ol_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            win_q   <= win_d;
            ph_q    <= ph_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
`ifdef POOL_OUT_LAST_EN
            pair_q  <= pair_d;
            ol_q    <= ol_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        win_d        = win_q;
        ph_d         = ph_q;
        ov_d         = ov_q;
        od_d         = od_q;
`ifdef POOL_OUT_LAST_EN
        pair_d       = pair_q;
        ol_d         = ol_q;
`endif
        bus.in_ready = 1'b0;
        cell_clear   = 1'b1;
        cell_data    = '0;
        base         = WR_W'({win_q, 1'b0});

        if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
`ifdef POOL_OUT_LAST_EN
            ol_d = 1'b0;
`endif
        end

        case (state_q)
            LOAD: begin
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    if (wr_q == WR_LAST) begin
                        wr_d    = '0;
                        win_d   = '0;
                        ph_d    = '0;
                        state_d = POOL;
                    end else begin
                        wr_d = wr_q + WR_W'(1);
                    end
                end
            end
            POOL: begin
                cell_clear = (ph_q == 3'd0);
                case (ph_q)
                    3'd1:    cell_data = row_buf[base];
                    3'd2:    cell_data = row_buf[base + WR_W'(1)];
                    3'd3:    cell_data = row_buf[base + WR_W'(FM_WIDTH)];
                    3'd4:    cell_data = row_buf[base + WR_W'(FM_WIDTH + 1)];
                    default: cell_data = '0;
                endcase
                // Phase 5 holds until the output slot frees, keeping the cell's result intact.
                if (ph_q == 3'd5) begin
                    if (!ov_q || bus.out_ready) begin
                        ov_d = 1'b1;
                        od_d = cell_result;
                        ph_d = '0;
`ifdef POOL_OUT_LAST_EN
                        ol_d = (win_q == WIN_LAST) && (pair_q == PAIR_LAST);
`endif
                        if (win_q == WIN_LAST) begin
                            state_d = LOAD;
                            win_d   = '0;
`ifdef POOL_OUT_LAST_EN
                            pair_d  = (pair_q == PAIR_LAST) ? '0 : pair_q + PAIR_W'(1);
`endif
                        end else begin
                            win_d = win_q + WIN_W'(1);
                        end
                    end
                end else begin
                    ph_d = ph_q + 3'd1;
                end
            end
            default: state_d = LOAD;
        endcase

        if (rst) begin
            cell_clear = 1'b1;
            cell_data  = '0;
        end
    end
endmodule

// File: doc/pooling_window_feeder.md
POOLING_WINDOW_FEEDER -- requirements
Module: pooling_window_feeder

Interface
REQ-001 Parameter FM_WIDTH, default 8: feature-map columns; even, >= 2.
REQ-002 Parameter FM_HEIGHT, default 8: feature-map rows; even, >= 2; used only when POOL_OUT_LAST_EN is defined.
REQ-003 Element width SHALL be the global `DATA_WIDTH (IEEE-754 single, 32 bits).
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  in_data holds a row-major feature-map element.
REQ-007 Port in_data  input  `DATA_WIDTH  feature-map element.
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port cell_data  output  `DATA_WIDTH  drives the max cell's a input.
REQ-010 Port cell_clear  output  1  drives the max cell's clear input.
REQ-011 Port cell_result  input  `DATA_WIDTH  the max cell's registered result.
REQ-012 Port out_valid  output  1  out_data holds one pooled value.
REQ-013 Port out_data  output  `DATA_WIDTH  2x2 max-pooled value.
REQ-014 Port out_ready  input  1  consumer accepts out_data.

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-016 An output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-017 FSM states: LOAD and POOL only.
REQ-018 LOAD: in_ready=1; each transfer writes a 2*FM_WIDTH-entry row-pair buffer at the write index (row 0 at indices 0..FM_WIDTH-1, row 1 after); the index increments.
REQ-019 LOAD->POOL on the transfer that fills index 2*FM_WIDTH-1; the write index returns to 0.
REQ-020 POOL: in_ready=0; windows k=0..FM_WIDTH/2-1 are processed in order, 6 phases per window.
REQ-021 Phase 0: cell_clear=1, cell_data=0.
REQ-022 Phases 1-4: cell_clear=0; cell_data = r0[2k], r0[2k+1], r1[2k], r1[2k+1] respectively.
REQ-023 Phase 5 (capture): cell_clear=0, cell_data=0; cell_result SHALL be loaded into out_data with out_valid set iff out_valid=0 or out_ready=1 this cycle.
REQ-024 Otherwise phase 5 SHALL repeat (stall) with outputs unchanged; the cell is never cleared before capture.
REQ-025 A simultaneous output transfer and capture SHALL leave out_valid=1 holding the new value.
REQ-026 An output transfer without capture SHALL clear out_valid.
REQ-027 Capture of the last window SHALL return the FSM to LOAD on the next cycle.
REQ-028 Negative-only windows SHALL yield +0.0 (the cell clears to zero); this is required behaviour.
REQ-029 Outside POOL, cell_clear=1 and cell_data=0.
REQ-030 Throughput: 2*FM_WIDTH load cycles plus 3*FM_WIDTH pool cycles per row pair when unstalled.

Reset
REQ-031 While rst=1 at a clock edge: state LOAD, all counters 0, out_valid=0, out_data=0, cell_clear=1, cell_data=0.
REQ-032 In reset, in_ready SHALL be 0; from the first non-reset cycle it SHALL follow REQ-018/REQ-020.
REQ-033 Buffer contents are not reset; reset mid-POOL or mid-LOAD SHALL discard the partial row pair.

Configuration
REQ-034 Macro POOL_OUT_LAST_EN.
REQ-035 With POOL_OUT_LAST_EN defined: extra port out_last (output, 1); a row-pair counter 0..FM_HEIGHT/2-1 is reset to 0.
REQ-036 out_last SHALL be 1 with the last window of the last row pair, and 0 otherwise.
REQ-037 Once that last window is captured, the row-pair counter SHALL wrap to 0.
REQ-038 Without POOL_OUT_LAST_EN: no out_last port and no row-pair counter; all other behaviour identical.

Verification
REQ-039 FM_WIDTH=2; rows {1.0,2.0},{3.0,4.0}; out_ready=1 -> one output 0x40800000; in_ready returns to 1 after 6 POOL cycles.
REQ-040 FM_WIDTH=4; rows {4.0,1.0,1.0,2.0},{3.0,2.0,3.0,1.0} -> outputs 0x40800000 then 0x40400000, in order.
REQ-041 All inputs 0xBF800000 (-1.0) -> every output 0x00000000.
REQ-042 out_ready=0 for 20 cycles during POOL -> FSM stalls in phase 5 of window 1; out_data keeps window 0; cell_clear stays 0; window 1 is correct on release.
REQ-043 rst=1 during phase 3 -> next cycle out_valid=0, in_ready=1; a fresh row pair then pools correctly.
REQ-044 POOL_OUT_LAST_EN, FM_WIDTH=2, FM_HEIGHT=4, two row pairs -> out_last=0 on output 1 and 1 on output 2; a third row pair gives out_last=0.
